// File: rtl/fd_prog.sv
// fd_prog: programmable integer clock divider with glitch-free ratio reload
// and single-cycle rise/fall strobes aligned to the registered div_out.
module fd_prog #(
   parameter int CNT_W     = 8,
   parameter int RST_DIV   = 4,
   parameter bit RST_LEVEL = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [CNT_W-1:0] div_val,
   input  logic             div_load,
   output logic             div_busy,
   output logic [CNT_W-1:0] div_cur,
   output logic             div_out,
   output logic             div_rise,
   output logic             div_fall
);
   logic [CNT_W-1:0] cnt_q, cnt_d, cur_q, cur_d, pend_q, pend_d, cnt_nx;
   logic             busy_q, busy_d, out_q, out_d, rise_q, rise_d, fall_q, fall_d;
   logic             bnd, out_nx;
   logic [CNT_W:0]   h;
   always_comb begin
      bnd    = en && (cnt_q == cur_q - 1'b1);
      cnt_nx = bnd ? '0 : cnt_q + 1'b1;
      // one extra bit keeps N+1 from wrapping at the largest ratio
      h      = ({1'b0, cur_q} + 1'b1) >> 1;
      out_nx = {1'b0, cnt_nx} < h;
      cnt_d  = en ? cnt_nx : cnt_q;
      out_d  = en ? out_nx : out_q;
      rise_d = en & out_nx & ~out_q;
      fall_d = en & ~out_nx & out_q;
      cur_d  = (busy_q && bnd) ? pend_q : cur_q;
      busy_d = busy_q ? ~bnd : div_load;
      pend_d = (!busy_q && div_load) ?
               ((div_val[CNT_W-1:1] == '0) ? CNT_W'(2) : div_val) : pend_q;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         cur_q  <= CNT_W'(RST_DIV);
         pend_q <= '0;
         busy_q <= 1'b0;
         out_q  <= RST_LEVEL;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         cur_q  <= cur_d;
         pend_q <= pend_d;
         busy_q <= busy_d;
         out_q  <= out_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end
   assign div_busy = busy_q;
   assign div_cur  = cur_q;
   assign div_out  = out_q;
   assign div_rise = rise_q;
   assign div_fall = fall_q;
endmodule
